// File: rtl/alu_ctrl_seq_if.sv
// Handshake bundle between the main control unit, alu_ctrl_seq and the ALU/mul-div consumer.
interface alu_ctrl_seq_if #(
  parameter int unsigned AOP_W  = 3,
  parameter int unsigned FUNC_W = 6,
  parameter int unsigned SEL_W  = 4
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [AOP_W-1:0]  Aop;
  logic [FUNC_W-1:0] func;
  logic              out_valid;
  logic              out_ready;
  logic [SEL_W-1:0]  alu_sel;
  logic              multi;
  logic              illegal;
  logic              busy;

  modport master (
    output flush, in_valid, Aop, func, out_ready,
    input  in_ready, out_valid, alu_sel, multi, illegal, busy
  );

  modport slave (
    input  flush, in_valid, Aop, func, out_ready,
    output in_ready, out_valid, alu_sel, multi, illegal, busy
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder with valid/ready handshakes; MULT/DIV are held for a
// fixed latency window (busy) before their select code is presented as valid.
module alu_ctrl_seq #(
  parameter int unsigned AOP_W   = 3,
  parameter int unsigned FUNC_W  = 6,
  parameter int unsigned SEL_W   = 4,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32
) (
  input logic            clk,
  input logic            rst_n,
  alu_ctrl_seq_if.slave  bus
);
  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {IDLE, FULL, MULTI} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] dec_sel;
  logic             dec_multi;
  logic             dec_div;
  logic             dec_illegal;
  logic             accept;

  always_comb begin
    dec_sel     = '0;
    dec_multi   = 1'b0;
    dec_div     = 1'b0;
    dec_illegal = 1'b0;
    case (bus.Aop)
      AOP_W'(3'b000): dec_sel = SEL_W'(4'd1);
      AOP_W'(3'b001): dec_sel = SEL_W'(4'd2);
      AOP_W'(3'b011): dec_sel = SEL_W'(4'd3);
      AOP_W'(3'b100): dec_sel = SEL_W'(4'd4);
      AOP_W'(3'b101): dec_sel = SEL_W'(4'd5);
      AOP_W'(3'b010): begin
        case (bus.func)
          FUNC_W'(6'b100000): dec_sel = SEL_W'(4'd1);
          FUNC_W'(6'b100010): dec_sel = SEL_W'(4'd2);
          FUNC_W'(6'b100100): dec_sel = SEL_W'(4'd3);
          FUNC_W'(6'b100101): dec_sel = SEL_W'(4'd4);
          FUNC_W'(6'b101010): dec_sel = SEL_W'(4'd5);
          FUNC_W'(6'b101011): dec_sel = SEL_W'(4'd6);
          FUNC_W'(6'b100111): dec_sel = SEL_W'(4'd7);
          FUNC_W'(6'b100110): dec_sel = SEL_W'(4'd8);
          FUNC_W'(6'b000000): dec_sel = SEL_W'(4'd9);
          FUNC_W'(6'b000010): dec_sel = SEL_W'(4'd10);
          FUNC_W'(6'b000011): dec_sel = SEL_W'(4'd11);
          FUNC_W'(6'b011000): begin
            dec_sel   = SEL_W'(4'd12);
            dec_multi = 1'b1;
          end
          FUNC_W'(6'b011010): begin
            dec_sel   = SEL_W'(4'd13);
            dec_multi = 1'b1;
            dec_div   = 1'b1;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign bus.in_ready = rst_n & ((state == IDLE) | ((state == FULL) & bus.out_ready));
  assign accept       = bus.in_valid & bus.in_ready;

  // Priority: reset, then flush, then a new accept, then draining/counting the held op.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.out_valid <= 1'b0;
      bus.alu_sel   <= '0;
      bus.multi     <= 1'b0;
      bus.illegal   <= 1'b0;
      bus.busy      <= 1'b0;
    end else if (bus.flush) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.out_valid <= 1'b0;
      bus.multi     <= 1'b0;
      bus.illegal   <= 1'b0;
      bus.busy      <= 1'b0;
    end else if (accept) begin
      bus.alu_sel <= dec_sel;
      bus.multi   <= dec_multi;
      bus.illegal <= dec_illegal;
      if (dec_multi) begin
        state         <= MULTI;
        cnt           <= dec_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
        bus.out_valid <= 1'b0;
        bus.busy      <= 1'b1;
      end else begin
        state         <= FULL;
        bus.out_valid <= 1'b1;
        bus.busy      <= 1'b0;
      end
    end else begin
      case (state)
        FULL: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
          end
        end
        MULTI: begin
          if (cnt == '0) begin
            state         <= FULL;
            bus.out_valid <= 1'b1;
            bus.busy      <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed-vector bench for alu_ctrl_seq with hand-computed expected outputs.
module tb_alu_ctrl_seq;
  localparam int unsigned MUL_LAT = 4;
  localparam int unsigned DIV_LAT = 32;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  alu_ctrl_seq_if #(.AOP_W(3), .FUNC_W(6), .SEL_W(4)) bus ();

  alu_ctrl_seq #(
    .AOP_W(3), .FUNC_W(6), .SEL_W(4), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] aop, input logic [5:0] fn);
    bus.in_valid = v;
    bus.Aop      = aop;
    bus.func     = fn;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_alu_sel"},   32'(bus.alu_sel),   32'd0);
    check({tag, "_multi"},     32'(bus.multi),     32'd0);
    check({tag, "_illegal"},   32'(bus.illegal),   32'd0);
    check({tag, "_busy"},      32'(bus.busy),      32'd0);
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
  endtask

  logic [5:0] t2_func [4] = '{6'b100000, 6'b100010, 6'b101011, 6'b000011};
  logic [3:0] t2_sel  [4] = '{4'd1, 4'd2, 4'd6, 4'd11};

  initial begin
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 3'b000, 6'b000000);

    // T1: reset held for two edges
    tick();
    tick();
    check_idle_outputs("t1_reset");
    rst_n = 1'b1;
    #1;
    check("t1_in_ready_release", 32'(bus.in_ready), 32'd1);

    // T2: back-to-back R-type ops
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'b010, t2_func[i]);
      #1;
      check("t2_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      check("t2_out_valid", 32'(bus.out_valid), 32'd1);
      check("t2_alu_sel",   32'(bus.alu_sel),   32'(t2_sel[i]));
      check("t2_illegal",   32'(bus.illegal),   32'd0);
      check("t2_multi",     32'(bus.multi),     32'd0);
    end
    drive(1'b0, 3'b000, 6'b000000);
    tick();
    check("t2_drain", 32'(bus.out_valid), 32'd0);

    // T3: DIV busy window
    drive(1'b1, 3'b010, 6'b011010);
    tick();
    drive(1'b0, 3'b000, 6'b000000);
    for (int c = 0; c < int'(DIV_LAT); c++) begin
      check("t3_busy",      32'(bus.busy),      32'd1);
      check("t3_in_ready",  32'(bus.in_ready),  32'd0);
      check("t3_out_valid", 32'(bus.out_valid), 32'd0);
      tick();
    end
    check("t3_out_valid_done", 32'(bus.out_valid), 32'd1);
    check("t3_alu_sel",        32'(bus.alu_sel),   32'd13);
    check("t3_multi",          32'(bus.multi),     32'd1);
    check("t3_busy_done",      32'(bus.busy),      32'd0);
    tick();
    check("t3_drain", 32'(bus.out_valid), 32'd0);

    // T4: illegal funct, then illegal Aop
    drive(1'b1, 3'b010, 6'b111111);
    tick();
    check("t4a_out_valid", 32'(bus.out_valid), 32'd1);
    check("t4a_alu_sel",   32'(bus.alu_sel),   32'd0);
    check("t4a_illegal",   32'(bus.illegal),   32'd1);
    drive(1'b1, 3'b110, 6'b100000);
    tick();
    check("t4b_out_valid", 32'(bus.out_valid), 32'd1);
    check("t4b_alu_sel",   32'(bus.alu_sel),   32'd0);
    check("t4b_illegal",   32'(bus.illegal),   32'd1);
    drive(1'b0, 3'b000, 6'b000000);
    tick();
    check("t4_drain", 32'(bus.out_valid), 32'd0);

    // T5: backpressure holds ADD while a SUB waits
    bus.out_ready = 1'b0;
    drive(1'b1, 3'b000, 6'b000000);
    tick();
    drive(1'b1, 3'b001, 6'b000000);
    for (int c = 0; c < 5; c++) begin
      #1;
      check("t5_held_valid",    32'(bus.out_valid), 32'd1);
      check("t5_held_sel",      32'(bus.alu_sel),   32'd1);
      check("t5_held_in_ready", 32'(bus.in_ready),  32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check("t5_in_ready_same_cycle", 32'(bus.in_ready), 32'd1);
    tick();
    check("t5_replace_sel",   32'(bus.alu_sel),   32'd2);
    check("t5_replace_valid", 32'(bus.out_valid), 32'd1);
    drive(1'b0, 3'b000, 6'b000000);
    tick();
    check("t5_drain", 32'(bus.out_valid), 32'd0);

    // T6: flush an in-flight MULT, then ADD
    drive(1'b1, 3'b010, 6'b011000);
    tick();
    drive(1'b0, 3'b000, 6'b000000);
    check("t6_busy_start", 32'(bus.busy), 32'd1);
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("t6_flush_busy",  32'(bus.busy),      32'd0);
    check("t6_flush_valid", 32'(bus.out_valid), 32'd0);
    check("t6_flush_multi", 32'(bus.multi),     32'd0);
    drive(1'b1, 3'b000, 6'b000000);
    tick();
    check("t6_add_valid", 32'(bus.out_valid), 32'd1);
    check("t6_add_sel",   32'(bus.alu_sel),   32'd1);
    check("t6_add_multi", 32'(bus.multi),     32'd0);
    drive(1'b0, 3'b000, 6'b000000);
    for (int c = 0; c < int'(MUL_LAT) + 3; c++) begin
      tick();
      check("t6_no_stale_valid", 32'(bus.out_valid), 32'd0);
    end

    // flush wins over a simultaneous accept
    drive(1'b1, 3'b000, 6'b000000);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    drive(1'b0, 3'b000, 6'b000000);
    check("flush_over_accept", 32'(bus.out_valid), 32'd0);

    // Mid-stream reset during MULT
    drive(1'b1, 3'b010, 6'b011000);
    tick();
    drive(1'b0, 3'b000, 6'b000000);
    tick();
    rst_n = 1'b0;
    #1;
    check("t1_mid_in_ready_low", 32'(bus.in_ready), 32'd0);
    tick();
    tick();
    check_idle_outputs("t1_mid_reset");
    rst_n = 1'b1;
    #1;
    check("t1_mid_in_ready_release", 32'(bus.in_ready), 32'd1);
    for (int c = 0; c < int'(MUL_LAT) + 2; c++) begin
      tick();
      check("t1_mid_no_valid", 32'(bus.out_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
